// File: rtl/ascii_bcd_seq_ctrl.sv
`timescale 1ns/1ps
// ascii_bcd_seq_ctrl
// Collects N/8 ASCII characters (first = most significant digit), presents
// them to an external combinational ASCII->BCD converter, captures the BCD
// result and error flag, and hands the word downstream on valid/ready.
// Keeps saturating counts of delivered words and of delivered error words.
module ascii_bcd_seq_ctrl #(
  parameter int N     = 32,
  parameter int M     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [7:0]       in_char,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     conv_ascii,
  input  logic [M-1:0]     conv_bcd,
  input  logic             conv_err,
  output logic [M-1:0]     out_bcd,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int NCH   = N / 8;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONV    = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t             state_q,      state_d;
  logic [IDX_W-1:0]   idx_q,        idx_d;
  logic [N-1:0]       conv_ascii_q, conv_ascii_d;
  logic [M-1:0]       out_bcd_q,    out_bcd_d;
  logic               out_err_q,    out_err_d;
  logic               out_valid_q,  out_valid_d;
  logic               in_ready_q,   in_ready_d;
  logic [CNT_W-1:0]   word_cnt_q,   word_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q,    err_cnt_d;

  // Next-state computation: character assembly, result capture, handoff.
  // clear is resolved inside each state so a simultaneous character or
  // handoff is dropped rather than partially applied.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    conv_ascii_d = conv_ascii_q;
    out_bcd_d    = out_bcd_q;
    out_err_d    = out_err_q;
    word_cnt_d   = word_cnt_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      COLLECT: begin
        if (clear) begin
          idx_d = '0;
        end else if (in_valid) begin
          for (int unsigned k = 0; k < NCH; k++) begin
            if (idx_q == IDX_W'(k)) begin
              conv_ascii_d[N-1-8*k -: 8] = in_char;
            end
          end
          if (idx_q == IDX_W'(NCH - 1)) begin
            idx_d   = '0;
            state_d = CONV;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      CONV: begin
        if (clear) begin
          idx_d   = '0;
          state_d = COLLECT;
        end else begin
          out_bcd_d = conv_err ? '0 : conv_bcd;
          out_err_d = conv_err;
          state_d   = OUT;
        end
      end

      OUT: begin
        if (clear) begin
          idx_d   = '0;
          state_d = COLLECT;
        end else if (out_ready) begin
          if (word_cnt_q != '1) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
          if (out_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          state_d = COLLECT;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = COLLECT;
      end
    endcase

    in_ready_d  = (state_d == COLLECT);
    out_valid_d = (state_d == OUT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      idx_q        <= '0;
      conv_ascii_q <= '0;
      out_bcd_q    <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      word_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      conv_ascii_q <= conv_ascii_d;
      out_bcd_q    <= out_bcd_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      word_cnt_q   <= word_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign conv_ascii = conv_ascii_q;
  assign out_bcd    = out_bcd_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;
  assign word_cnt   = word_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
